// File: rtl/sp_ram_pkg.sv
// Shared types and constants for the byte-enabled single-port RAM (sp_ram_be).
package sp_ram_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef enum logic [1:0] {
      WR_NO_CHANGE   = 2'd0,
      WR_READ_FIRST  = 2'd1,
      WR_WRITE_FIRST = 2'd2
   } wr_mode_t;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_IDLE = 1'b1
   } state_t;

endpackage

// File: rtl/sp_ram_init_fsm.sv
// Power-up/reset initialisation sequencer: sweeps every word address once, then goes idle.
module sp_ram_init_fsm
   import sp_ram_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  init_busy,
   output logic                  init_we,
   output logic [ADDR_WIDTH-1:0] init_addr
);

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_INIT;
         cnt_q     <= '0;
         init_busy <= 1'b1;
      end else begin
         unique case (state_q)
            ST_INIT: begin
               cnt_q <= cnt_q + 1'b1;
               // The edge that writes the last address also ends the sequence.
               if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                  state_q   <= ST_IDLE;
                  init_busy <= 1'b0;
               end
            end
            ST_IDLE: begin
            end
         endcase
      end
   end

   assign init_we   = (state_q == ST_INIT);
   assign init_addr = cnt_q;

endmodule

// File: rtl/sp_ram_be.sv
// Single-port synchronous RAM with byte enables, selectable write-cycle dout and self-init.
// Optional extra output register stage when SP_RAM_OUT_REG_EN is defined.
module sp_ram_be
   import sp_ram_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH = 16,
   parameter int unsigned           ADDR_WIDTH = 4,
   parameter int unsigned           WR_MODE    = 0,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         chip_enable,
   input  logic                         write_enable,
   input  logic [DATA_WIDTH/BYTE_W-1:0] byte_enable,
   input  logic [ADDR_WIDTH-1:0]        address,
   input  logic [DATA_WIDTH-1:0]        din,
   output logic [DATA_WIDTH-1:0]        dout,
   output logic                         dout_valid,
   output logic                         init_busy
);

   localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
   localparam int unsigned NBYTES = DATA_WIDTH / BYTE_W;
   localparam wr_mode_t    MODE   = wr_mode_t'(WR_MODE[1:0]);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic                  init_we;
   logic [ADDR_WIDTH-1:0] init_addr;
   logic                  rd_en, wr_en;
   logic [DATA_WIDTH-1:0] old_word, merged_word;
   logic [DATA_WIDTH-1:0] dout_d, dout_q;
   logic                  valid_d, valid_q;

   sp_ram_init_fsm #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_init_fsm (
      .clk      (clk),
      .rst      (rst),
      .init_busy(init_busy),
      .init_we  (init_we),
      .init_addr(init_addr)
   );

   assign rd_en    = chip_enable & ~init_busy & ~write_enable;
   assign wr_en    = chip_enable & ~init_busy & write_enable;
   assign old_word = mem_q[address];

   always_comb begin
      merged_word = old_word;
      for (int unsigned i = 0; i < NBYTES; i++) begin
         if (byte_enable[i]) merged_word[i*BYTE_W +: BYTE_W] = din[i*BYTE_W +: BYTE_W];
      end
   end

   // Whole-word write of the merged value; unmasked bytes rewrite their old contents.
   always_ff @(posedge clk) begin
      if (init_we) begin
         mem_q[init_addr] <= INIT_VALUE;
      end else if (wr_en) begin
         mem_q[address] <= merged_word;
      end
   end

   always_comb begin
      dout_d  = dout_q;
      valid_d = 1'b0;
      if (rd_en) begin
         dout_d  = old_word;
         valid_d = 1'b1;
      end else if (wr_en) begin
         case (MODE)
            WR_READ_FIRST: begin
               dout_d  = old_word;
               valid_d = 1'b1;
            end
            WR_WRITE_FIRST: begin
               dout_d  = merged_word;
               valid_d = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         dout_q  <= dout_d;
         valid_q <= valid_d;
      end
   end

`ifdef SP_RAM_OUT_REG_EN
   logic [DATA_WIDTH-1:0] dout_q2;
   logic                  valid_q2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_q2  <= '0;
         valid_q2 <= 1'b0;
      end else begin
         dout_q2  <= dout_q;
         valid_q2 <= valid_q;
      end
   end

   assign dout       = dout_q2;
   assign dout_valid = valid_q2;
`else
   assign dout       = dout_q;
   assign dout_valid = valid_q;
`endif

endmodule

// File: tb/tb_sp_ram_be.sv
// Randomised scoreboard bench for sp_ram_be; one instance per write-cycle dout mode.
module tb_sp_ram_be;

   localparam int unsigned DW = 16;
   localparam int unsigned AW = 4;
`ifdef SP_RAM_OUT_REG_EN
   localparam int unsigned LAT = 2;
`else
   localparam int unsigned LAT = 1;
`endif

   typedef struct packed {
      int unsigned cyc;
      logic [15:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        chip_enable = 1'b0;
   logic        write_enable = 1'b0;
   logic [1:0]  byte_enable = 2'b00;
   logic [3:0]  address = 4'h0;
   logic [15:0] din = 16'h0000;
   logic [15:0] dout_a [3];
   logic        valid_a [3];
   logic        busy_a [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      sp_ram_be #(
         .DATA_WIDTH(DW),
         .ADDR_WIDTH(AW),
         .WR_MODE   (g),
         .INIT_VALUE(16'h0000)
      ) u_dut (
         .clk         (clk),
         .rst         (rst),
         .chip_enable (chip_enable),
         .write_enable(write_enable),
         .byte_enable (byte_enable),
         .address     (address),
         .din         (din),
         .dout        (dout_a[g]),
         .dout_valid  (valid_a[g]),
         .init_busy   (busy_a[g])
      );
   end

   // Reference state: word array, expected-output queues per mode, last dout seen per mode.
   exp_t        q0[$], q1[$], q2[$];
   logic [15:0] mem_m [16];
   logic [15:0] last_m [3];
   int unsigned edge_cnt = 0;
   int unsigned init_done_edge = 32'hFFFF_FFFF;
   int          n_checks = 0;
   int          n_fail = 0;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   task automatic push(input int m, input exp_t e);
      case (m)
         0: q0.push_back(e);
         1: q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic pop_if_due(input int m, output bit due, output exp_t e);
      due = 1'b0;
      e   = '0;
      case (m)
         0: if (q0.size() > 0 && q0[0].cyc == edge_cnt) begin due = 1'b1; e = q0.pop_front(); end
         1: if (q1.size() > 0 && q1[0].cyc == edge_cnt) begin due = 1'b1; e = q1.pop_front(); end
         default:
            if (q2.size() > 0 && q2[0].cyc == edge_cnt) begin due = 1'b1; e = q2.pop_front(); end
      endcase
   endtask

   // Monitor: every cycle each instance must match its queue head exactly on the due edge.
   initial begin
      bit   due;
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         for (int m = 0; m < 3; m++) begin
            check($sformatf("init_busy[mode%0d]", m), 16'(busy_a[m]),
                  16'(rst || edge_cnt < init_done_edge));
            pop_if_due(m, due, e);
            if (due) begin
               check($sformatf("dout_valid[mode%0d]", m), 16'(valid_a[m]), 16'd1);
               check($sformatf("dout[mode%0d]", m), dout_a[m], e.data);
               last_m[m] = e.data;
            end else begin
               check($sformatf("dout_valid_idle[mode%0d]", m), 16'(valid_a[m]), 16'd0);
               check($sformatf("dout_hold[mode%0d]", m), dout_a[m], last_m[m]);
            end
         end
      end
   end

   task automatic do_reset();
      rst            = 1'b1;
      chip_enable    = 1'b0;
      init_done_edge = 32'hFFFF_FFFF;
      q0.delete();
      q1.delete();
      q2.delete();
      for (int m = 0; m < 3; m++) last_m[m] = 16'h0000;
      @(posedge clk);
      #1;
      rst            = 1'b0;
      init_done_edge = edge_cnt + 16;
      for (int a = 0; a < 16; a++) mem_m[a] = 16'h0000;
   endtask

   // Drives one request for the next edge and records what each mode must answer.
   task automatic access(input bit ce, input bit we, input logic [1:0] be, input logic [3:0] a,
                         input logic [15:0] d);
      int unsigned n;
      logic [15:0] old_w, new_w;
      n            = edge_cnt;
      chip_enable  = ce;
      write_enable = we;
      byte_enable  = be;
      address      = a;
      din          = d;
      if (ce && !rst && n >= init_done_edge) begin
         old_w = mem_m[a];
         new_w = old_w;
         for (int i = 0; i < 2; i++) if (be[i]) new_w[8*i +: 8] = d[8*i +: 8];
         if (!we) begin
            for (int m = 0; m < 3; m++) push(m, exp_t'{cyc: n + LAT, data: old_w});
         end else begin
            push(1, exp_t'{cyc: n + LAT, data: old_w});
            push(2, exp_t'{cyc: n + LAT, data: new_w});
            mem_m[a] = new_w;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) access(1'b0, 1'b0, 2'b00, 4'h0, 16'h0000);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] r;
      do_reset();
      idle(16);
      for (int a = 0; a < 16; a++) access(1'b1, 1'b0, 2'b00, 4'(a), 16'($urandom));
      // Full and partial byte writes, then a fully masked write.
      access(1'b1, 1'b1, 2'b11, 4'd6, 16'hBEEF);
      access(1'b1, 1'b0, 2'b00, 4'd6, 16'h0000);
      idle(2);
      access(1'b1, 1'b1, 2'b01, 4'd6, 16'h12AB);
      access(1'b1, 1'b0, 2'b00, 4'd6, 16'h0000);
      access(1'b1, 1'b1, 2'b00, 4'd6, 16'hFFFF);
      access(1'b1, 1'b0, 2'b00, 4'd6, 16'h0000);
      access(1'b1, 1'b1, 2'b11, 4'd6, 16'hBEEF);
      access(1'b1, 1'b1, 2'b11, 4'd6, 16'h5555);
      access(1'b1, 1'b0, 2'b00, 4'd6, 16'h0000);
      idle(3);
      // Reset in the middle of init, with a read attempt while busy.
      do_reset();
      idle(7);
      do_reset();
      access(1'b1, 1'b0, 2'b00, 4'd3, 16'h0000);
      idle(16);
      access(1'b1, 1'b0, 2'b00, 4'd3, 16'h0000);
      // Back-to-back traffic.
      access(1'b1, 1'b1, 2'b11, 4'd1, 16'hA001);
      access(1'b1, 1'b1, 2'b11, 4'd2, 16'hA002);
      access(1'b1, 1'b1, 2'b11, 4'd3, 16'hA003);
      access(1'b1, 1'b0, 2'b00, 4'd1, 16'h0000);
      access(1'b1, 1'b0, 2'b00, 4'd2, 16'h0000);
      access(1'b1, 1'b0, 2'b00, 4'd3, 16'h0000);
      for (int k = 0; k < 400; k++) begin
         r = $urandom;
         access(r[0] | r[1], r[2], r[4:3], r[9] ? {2'b00, r[6:5]} : r[8:5], r[31:16]);
      end
      // Reset while traffic and outputs are in flight.
      access(1'b1, 1'b0, 2'b00, 4'd5, 16'h0000);
      do_reset();
      idle(16);
      for (int k = 0; k < 40; k++) begin
         r = $urandom;
         access(1'b1, r[2], r[4:3], {2'b00, r[6:5]}, r[31:16]);
      end
      idle(4);
      check("scoreboard_drain", 16'(q0.size() + q1.size() + q2.size()), 16'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
